// File: rtl/alu_mem_sequencer.sv
// Burst controller for the 8-bit ALU + 64-entry memory datapath.
// WRITE bursts push ALU results into consecutive addresses; READ bursts stream stored bytes out.
module alu_mem_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_sel,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] dp_a,
  output logic [DATA_W-1:0] dp_b,
  output logic [2:0]        dp_sel,
  output logic              dp_en,
  output logic [ADDR_W-1:0] dp_addr,
  input  logic [DATA_W-1:0] dp_rdata,
  input  logic              dp_zero,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   zero_count
);

  localparam logic [ADDR_W:0] DepthVal = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAP, RD_HOLD, FIN} stateT;

  stateT state, nextState;

  logic [2:0]        selReg;
  logic [ADDR_W-1:0] baseReg;
  logic [ADDR_W:0]   lenReg;
  logic [ADDR_W:0]   beatIdx;
  logic [ADDR_W:0]   lenClamped;
  logic [ADDR_W:0]   zeroCount;
  logic [DATA_W-1:0] outData;
  logic              outValid;
  logic              lastBeat;

  assign lenClamped = (cmd_len > DepthVal) ? DepthVal : cmd_len;
  assign lastBeat   = (beatIdx == (lenReg - 1'b1));
  // Address arithmetic truncates to ADDR_W bits, giving the required wrap-around.
  assign dp_addr    = baseReg + beatIdx[ADDR_W-1:0];

  assign busy       = (state != IDLE);
  assign out_valid  = outValid;
  assign out_data   = outData;
  assign zero_count = zeroCount;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    dp_en     = 1'b0;
    dp_a      = '0;
    dp_b      = '0;
    dp_sel    = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (lenClamped == '0) begin
            nextState = FIN;
          end else if (cmd_write) begin
            nextState = WR;
          end else begin
            nextState = RD_ADDR;
          end
        end
      end
      WR: begin
        in_ready = 1'b1;
        dp_a     = in_a;
        dp_b     = in_b;
        dp_sel   = selReg;
        dp_en    = in_valid;
        if (in_valid && lastBeat) begin
          nextState = FIN;
        end
      end
      RD_ADDR: nextState = RD_CAP;
      RD_CAP:  nextState = RD_HOLD;
      RD_HOLD: begin
        if (out_ready) begin
          nextState = lastBeat ? FIN : RD_ADDR;
        end
      end
      FIN: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Command latch, beat counter, zero tally and the read output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      selReg    <= '0;
      baseReg   <= '0;
      lenReg    <= '0;
      beatIdx   <= '0;
      zeroCount <= '0;
      outData   <= '0;
      outValid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            selReg  <= cmd_sel;
            baseReg <= cmd_base;
            lenReg  <= lenClamped;
            beatIdx <= '0;
            if (cmd_write && (lenClamped != '0)) begin
              zeroCount <= '0;
            end
          end
        end
        WR: begin
          if (in_valid) begin
            beatIdx <= beatIdx + 1'b1;
            if (dp_zero) begin
              zeroCount <= zeroCount + 1'b1;
            end
          end
        end
        RD_CAP: begin
          outData  <= dp_rdata;
          outValid <= 1'b1;
        end
        RD_HOLD: begin
          if (out_ready) begin
            outValid <= 1'b0;
            beatIdx  <= beatIdx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mem_sequencer.sv
// Directed bench for alu_mem_sequencer with a behavioural ALU + 64-entry memory
// (registered read) standing in for the datapath.
module tb_alu_mem_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_sel;
  logic [5:0] cmd_base;
  logic [6:0] cmd_len;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [7:0] dp_a, dp_b, dp_rdata;
  logic [2:0] dp_sel;
  logic       dp_en, dp_zero;
  logic [5:0] dp_addr;
  logic       busy, done;
  logic [6:0] zero_count;

  logic [7:0] aluRes;
  logic [7:0] mem [0:63];
  logic [7:0] expData [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_en(dp_en), .dp_addr(dp_addr),
    .dp_rdata(dp_rdata), .dp_zero(dp_zero),
    .busy(busy), .done(done), .zero_count(zero_count)
  );

  always_comb begin
    case (dp_sel)
      3'b000:  aluRes = dp_a + dp_b;
      3'b001:  aluRes = dp_a - dp_b;
      3'b010:  aluRes = dp_a & dp_b;
      3'b011:  aluRes = dp_a | dp_b;
      3'b100:  aluRes = dp_a ^ dp_b;
      default: aluRes = dp_a;
    endcase
  end
  assign dp_zero = (aluRes == 8'd0);

  always @(posedge clk) begin
    if (dp_en) mem[dp_addr] <= aluRes;
    dp_rdata <= mem[dp_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Offer one command and hold it for the single accepting edge.
  task automatic applyStimulus(input logic wr, input logic [2:0] sel, input logic [5:0] base, input logic [6:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_sel   = sel;
    cmd_base  = base;
    cmd_len   = len;
    #1;
    checkOutput("cmd_ready before accept", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic writeBeat(input logic [7:0] a, input logic [7:0] b, input logic [5:0] addr);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    #1;
    checkOutput("wr dp_en", dp_en, 1);
    checkOutput("wr dp_addr", dp_addr, addr);
    checkOutput("wr dp_a", dp_a, a);
    checkOutput("wr dp_b", dp_b, b);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic gapCycle(input logic [5:0] addr);
    in_valid = 1'b0;
    #1;
    checkOutput("gap dp_en", dp_en, 0);
    checkOutput("gap in_ready", in_ready, 1);
    checkOutput("gap dp_addr", dp_addr, addr);
    tick;
  endtask

  // Read burst with out_ready held high; expected bytes come from expData.
  task automatic readBurst(input logic [5:0] base, input int len);
    logic [5:0] expAddr;
    applyStimulus(1'b0, 3'b000, base, 7'(len));
    for (int k = 0; k < len; k++) begin
      expAddr = base + 6'(k);
      checkOutput("rd dp_addr", dp_addr, expAddr);
      checkOutput("rd dp_en", dp_en, 0);
      checkOutput("rd out_valid early", out_valid, 0);
      tick;
      tick;
      checkOutput("rd out_valid", out_valid, 1);
      checkOutput("rd out_data", out_data, expData[k]);
      tick;
    end
    checkOutput("rd done", done, 1);
    tick;
    checkOutput("rd done once", done, 0);
    checkOutput("rd busy after", busy, 0);
  endtask

  initial begin
    int enCount;
    int guard;
    logic doneSeen;

    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = 3'b000; cmd_base = 6'd7; cmd_len = 7'd5;
    in_valid = 1'b0; in_a = 8'hAA; in_b = 8'h55; out_ready = 1'b1;
    for (int k = 0; k < 64; k++) mem[k] = 8'h00;
    tick;
    tick;
    checkOutput("rst cmd_ready", cmd_ready, 1);
    checkOutput("rst in_ready", in_ready, 0);
    checkOutput("rst out_valid", out_valid, 0);
    checkOutput("rst out_data", out_data, 0);
    checkOutput("rst dp_en", dp_en, 0);
    checkOutput("rst dp_a", dp_a, 0);
    checkOutput("rst dp_addr", dp_addr, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst zero_count", zero_count, 0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    checkOutput("idle after reset", busy, 0);

    // WRITE add burst: 64+10, 100+11, 105+10, 90+11 -> 74,111,115,101
    applyStimulus(1'b1, 3'b000, 6'd0, 7'd4);
    checkOutput("wr busy", busy, 1);
    checkOutput("wr cmd_ready", cmd_ready, 0);
    writeBeat(8'd64, 8'd10, 6'd0);
    writeBeat(8'd100, 8'd11, 6'd1);
    writeBeat(8'd105, 8'd10, 6'd2);
    writeBeat(8'd90, 8'd11, 6'd3);
    checkOutput("wr1 done", done, 1);
    checkOutput("wr1 dp_en in FIN", dp_en, 0);
    tick;
    checkOutput("wr1 done once", done, 0);
    checkOutput("wr1 busy after", busy, 0);
    checkOutput("wr1 zero_count", zero_count, 0);

    expData[0] = 8'd74; expData[1] = 8'd111; expData[2] = 8'd115; expData[3] = 8'd101;
    readBurst(6'd0, 4);

    // READ len=2 from base 1 with consumer stalled for 5 cycles
    out_ready = 1'b0;
    applyStimulus(1'b0, 3'b000, 6'd1, 7'd2);
    tick;
    tick;
    checkOutput("stall out_valid", out_valid, 1);
    checkOutput("stall out_data", out_data, 111);
    for (int k = 0; k < 5; k++) begin
      tick;
      checkOutput("stall hold valid", out_valid, 1);
      checkOutput("stall hold data", out_data, 111);
      checkOutput("stall hold addr", dp_addr, 1);
    end
    out_ready = 1'b1;
    tick;
    checkOutput("stall resume addr", dp_addr, 2);
    checkOutput("stall resume valid", out_valid, 0);
    tick;
    tick;
    checkOutput("stall beat2 data", out_data, 115);
    tick;
    checkOutput("stall done", done, 1);
    tick;

    // WRITE sub burst wrapping 62,63,0,1 with gaps; 7-7 gives a zero
    applyStimulus(1'b1, 3'b001, 6'd62, 7'd4);
    writeBeat(8'd5, 8'd3, 6'd62);
    gapCycle(6'd63);
    writeBeat(8'd7, 8'd7, 6'd63);
    gapCycle(6'd0);
    gapCycle(6'd0);
    writeBeat(8'd9, 8'd1, 6'd0);
    writeBeat(8'd20, 8'd4, 6'd1);
    checkOutput("wrap done", done, 1);
    tick;
    checkOutput("wrap zero_count", zero_count, 1);
    expData[0] = 8'd2; expData[1] = 8'd0; expData[2] = 8'd8; expData[3] = 8'd16;
    readBurst(6'd62, 4);

    // len=0: straight to FIN, no datapath access, zero_count untouched
    applyStimulus(1'b1, 3'b000, 6'd3, 7'd0);
    checkOutput("len0 done", done, 1);
    checkOutput("len0 dp_en", dp_en, 0);
    checkOutput("len0 zero_count kept", zero_count, 1);
    tick;
    checkOutput("len0 idle", busy, 0);

    // len=100 clamps to 64 beats; AND with 0x0F is zero at beats 0,16,32,48
    applyStimulus(1'b1, 3'b010, 6'd5, 7'd100);
    in_valid = 1'b1;
    in_a = 8'h0F;
    enCount = 0;
    guard = 0;
    doneSeen = 1'b0;
    while (!doneSeen && guard < 100) begin
      in_b = enCount[7:0];
      #1;
      if (done) begin
        doneSeen = 1'b1;
      end else begin
        if (dp_en) enCount++;
        tick;
        guard++;
      end
    end
    in_valid = 1'b0;
    checkOutput("len100 done seen", doneSeen, 1);
    checkOutput("len100 beat count", enCount, 64);
    tick;
    checkOutput("len100 zero_count", zero_count, 4);

    // Reset after beat 3 of a 10-beat write
    applyStimulus(1'b1, 3'b000, 6'd10, 7'd10);
    writeBeat(8'd1, 8'd1, 6'd10);
    writeBeat(8'd2, 8'd2, 6'd11);
    writeBeat(8'd3, 8'd3, 6'd12);
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick;
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst done", done, 0);
    checkOutput("midrst cmd_ready", cmd_ready, 1);
    checkOutput("midrst in_ready", in_ready, 0);
    checkOutput("midrst dp_addr", dp_addr, 0);
    checkOutput("midrst zero_count", zero_count, 0);
    rst_n = 1'b1;
    expData[0] = 8'd2; expData[1] = 8'd4; expData[2] = 8'd6;
    readBurst(6'd10, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
